irq_controller: RTL and testbench

- Parametrised interrupt controller for the single-cycle MIPS core; the generalised successor of the 3-line fixed-priority interrupt logic.
- Latches rising edges on NUM_IRQ request lines and applies a per-channel mask and a global enable.
- Supports fixed-priority nested interrupts with an EPC/channel return stack of depth NEST_DEPTH.
- The CPU muxes `vector` into its PC input when `take` is high and uses `epc` on `eret`.

---
 rtl/irq_controller.sv | 161 ++++++++++++++++
 tb/tb_irq_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Fixed-priority nested interrupt controller for the single-cycle MIPS core.
// Latency: request edge -> pending after 1 clock (3 clocks with IRQ_SYNC_EN); take is combinational.
// Backpressure: none; requests stay pending while masked, disabled, outranked or at full nesting depth.
//
// Optional feature macro: IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   irq_in                   request lines (rising edge requests service)
//   mask_we/mask_wdata       mask register write (1 = masked)
//   gie_we/gie_wdata         global interrupt enable write
//   pc_next                  CPU next-PC, pushed as EPC when an interrupt is taken
//   eret                     exception return executing this cycle
//   take, vector             CPU loads vector into PC when take is high
//   epc                      return address at top of stack (0 when empty)
//   mask, gie, pending, in_service, depth, eret_err   status
module irq_controller #(
    parameter int                  NUM_IRQ         = 8,
    parameter int                  PC_WIDTH        = 32,
    parameter int                  NEST_DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0] VEC_BASE        = PC_WIDTH'(32'h0000_0400),
    parameter int                  VEC_STRIDE_LOG2 = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_IRQ-1:0]                 irq_in,
    input  logic                               mask_we,
    input  logic [NUM_IRQ-1:0]                 mask_wdata,
    input  logic                               gie_we,
    input  logic                               gie_wdata,
    input  logic [PC_WIDTH-1:0]                pc_next,
    input  logic                               eret,
    output logic                               take,
    output logic [PC_WIDTH-1:0]                vector,
    output logic [PC_WIDTH-1:0]                epc,
    output logic [NUM_IRQ-1:0]                 mask,
    output logic                               gie,
    output logic [NUM_IRQ-1:0]                 pending,
    output logic [NUM_IRQ-1:0]                 in_service,
    output logic [$clog2(NEST_DEPTH+1)-1:0]    depth,
    output logic                               eret_err
);

    localparam int DW = $clog2(NEST_DEPTH + 1);
    localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DW-1:0] MAX_DEPTH = DW'(NEST_DEPTH);

    // ---------------- request edge detection ----------------
    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_src = sync2;
`else
    assign irq_src = irq_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= '0;
        else     irq_q <= irq_src;
    end

    assign rise = irq_src & ~irq_q;

    // ---------------- arbitration ----------------
    logic [NUM_IRQ-1:0] allow;
    logic [NUM_IRQ-1:0] eligible;
    logic [CW-1:0]      winner;
    logic               gate;

    // Only channels strictly above the highest-priority active handler may preempt.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        allow = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in_service[i]) seen = 1'b1;
            allow[i] = ~seen;
        end
    end

    // eret suppresses takes so the return completes before re-arbitration.
    assign gate     = gie & (depth < MAX_DEPTH) & ~eret;
    assign eligible = pending & ~mask & allow & {NUM_IRQ{gate}};
    assign take     = |eligible;

    // Scan downwards so the lowest eligible index is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CW'(i);
        end
    end

    assign vector = take ? (VEC_BASE + (PC_WIDTH'(winner) << VEC_STRIDE_LOG2)) : '0;

    // ---------------- return stack ----------------
    logic [PC_WIDTH-1:0] stk_pc [NEST_DEPTH];
    logic [CW-1:0]       stk_ch [NEST_DEPTH];
    logic [SW-1:0]       top_idx;
    logic [SW-1:0]       push_idx;
    logic                pop;
    logic [NUM_IRQ-1:0]  take_1h;
    logic [NUM_IRQ-1:0]  pop_1h;

    assign top_idx  = SW'(depth - DW'(1));
    assign push_idx = SW'(depth);
    assign pop      = eret & (depth != '0);
    assign epc      = (depth != '0) ? stk_pc[top_idx] : '0;
    assign take_1h  = take ? (NUM_IRQ'(1) << winner) : '0;
    assign pop_1h   = pop ? (NUM_IRQ'(1) << stk_ch[top_idx]) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_pc[i] <= '0;
                stk_ch[i] <= '0;
            end
        end else if (take) begin
            stk_pc[push_idx] <= pc_next;
            stk_ch[push_idx] <= winner;
        end
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
            mask       <= '0;
            gie        <= 1'b1;
            depth      <= '0;
            eret_err   <= 1'b0;
        end else begin
            if (mask_we) mask <= mask_wdata;
            if (gie_we)  gie  <= gie_wdata;
            // A new edge on the channel being taken re-arms it.
            pending    <= (pending & ~take_1h) | rise;
            in_service <= (in_service & ~pop_1h) | take_1h;
            if (take)     depth <= depth + DW'(1);
            else if (pop) depth <= depth - DW'(1);
            if (eret && (depth == '0)) eret_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        gie_we;
    logic        gie_wdata;
    logic [31:0] pc_next;
    logic        eret;

    logic        take,  take2;
    logic [31:0] vector, vector2;
    logic [31:0] epc, epc2;
    logic [7:0]  mask, mask2;
    logic        gie, gie2;
    logic [7:0]  pending, pending2;
    logic [7:0]  in_service, in_service2;
    logic [2:0]  depth;
    logic [1:0]  depth2;
    logic        eret_err, eret_err2;

    int checks = 0;
    int errors = 0;

    irq_controller dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_we(gie_we), .gie_wdata(gie_wdata),
        .pc_next(pc_next), .eret(eret),
        .take(take), .vector(vector), .epc(epc), .mask(mask), .gie(gie),
        .pending(pending), .in_service(in_service), .depth(depth), .eret_err(eret_err)
    );

    irq_controller #(.NEST_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .gie_we(gie_we), .gie_wdata(gie_wdata),
        .pc_next(pc_next), .eret(eret),
        .take(take2), .vector(vector2), .epc(epc2), .mask(mask2), .gie(gie2),
        .pending(pending2), .in_service(in_service2), .depth(depth2), .eret_err(eret_err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        gie_we = 1'b0; gie_wdata = 1'b0; eret = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // One-cycle pulse, then wait until it is visible in pending.
    task automatic pulse(input logic [7:0] b);
        irq_in = b;
        cyc();
        irq_in = '0;
        repeat (LAT - 1) cyc();
        #1;
    endtask

    initial begin
        pc_next = 32'h104;
        do_reset();
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_in_service", 32'(in_service), 32'h00);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_gie", 32'(gie), 32'h1);
        chk("rst_take", 32'(take), 32'h0);
        chk("rst_epc", epc, 32'h0);

        // Basic take of channel 3.
        pulse(8'h08);
        chk("t1_pending", 32'(pending), 32'h08);
        chk("t1_take", 32'(take), 32'h1);
        chk("t1_vector", vector, 32'h430);
        cyc();
        chk("t1_in_service", 32'(in_service), 32'h08);
        chk("t1_depth", 32'(depth), 32'h1);
        chk("t1_epc", epc, 32'h104);
        chk("t1_pending_clr", 32'(pending), 32'h00);
        chk("t1_take_off", 32'(take), 32'h0);

        // Nesting: ch1 preempts ch3, ch5 waits.
        pulse(8'h02);
        chk("t2_take1", 32'(take), 32'h1);
        chk("t2_vector1", vector, 32'h410);
        pc_next = 32'h200;
        cyc();
        chk("t2_depth2", 32'(depth), 32'h2);
        chk("t2_insvc", 32'(in_service), 32'h0A);
        chk("t2_epc", epc, 32'h200);
        pulse(8'h20);
        chk("t2_pend5", 32'(pending), 32'h20);
        chk("t2_take5_blocked", 32'(take), 32'h0);
        eret = 1'b1;
        #1;
        chk("t2_eret_epc", epc, 32'h200);
        chk("t2_eret_take", 32'(take), 32'h0);
        cyc();
        eret = 1'b0;
        #1;
        chk("t2_pop_depth", 32'(depth), 32'h1);
        chk("t2_pop_insvc", 32'(in_service), 32'h08);
        chk("t2_pop_epc", epc, 32'h104);
        chk("t2_ch5_below_3", 32'(take), 32'h0);
        eret = 1'b1;
        #1;
        chk("t2_eret2_take", 32'(take), 32'h0);
        cyc();
        eret = 1'b0;
        #1;
        chk("t2_ch5_take", 32'(take), 32'h1);
        chk("t2_ch5_vector", vector, 32'h450);
        cyc();
        chk("t2_ch5_insvc", 32'(in_service), 32'h20);
        chk("t2_ch5_epc", epc, 32'h200);

        // Masking.
        do_reset();
        mask_we = 1'b1; mask_wdata = 8'h01;
        cyc();
        mask_we = 1'b0;
        #1;
        chk("t3_mask", 32'(mask), 32'h01);
        pulse(8'h01);
        chk("t3_pending", 32'(pending), 32'h01);
        chk("t3_masked_take", 32'(take), 32'h0);
        mask_we = 1'b1; mask_wdata = 8'h00;
        #1;
        chk("t3_old_mask_take", 32'(take), 32'h0);
        cyc();
        mask_we = 1'b0;
        #1;
        chk("t3_unmask_take", 32'(take), 32'h1);
        chk("t3_vector", vector, 32'h400);
        cyc();
        chk("t3_insvc", 32'(in_service), 32'h01);

        // Nest limit on the 2-deep instance.
        do_reset();
        pulse(8'h80);
        chk("t4_take7", 32'(take2), 32'h1);
        chk("t4_vec7", vector2, 32'h470);
        cyc();
        pulse(8'h40);
        chk("t4_take6", 32'(take2), 32'h1);
        chk("t4_vec6", vector2, 32'h460);
        cyc();
        chk("t4_depth2", 32'(depth2), 32'h2);
        pulse(8'h01);
        chk("t4_full_take", 32'(take2), 32'h0);
        chk("t4_full_pend", 32'(pending2), 32'h01);
        eret = 1'b1;
        cyc();
        eret = 1'b0;
        #1;
        chk("t4_depth1", 32'(depth2), 32'h1);
        chk("t4_take0", 32'(take2), 32'h1);
        chk("t4_vec0", vector2, 32'h400);

        // eret at depth 0, then eret colliding with a request.
        do_reset();
        eret = 1'b1;
        cyc();
        eret = 1'b0;
        #1;
        chk("t5_eret_err", 32'(eret_err), 32'h1);
        chk("t5_depth0", 32'(depth), 32'h0);
        pulse(8'h10);
        chk("t5_take_pre", 32'(take), 32'h1);
        eret = 1'b1;
        #1;
        chk("t5_eret_wins", 32'(take), 32'h0);
        cyc();
        eret = 1'b0;
        #1;
        chk("t5_pend_kept", 32'(pending), 32'h10);
        chk("t5_depth_kept", 32'(depth), 32'h0);
        chk("t5_take_next", 32'(take), 32'h1);
        chk("t5_err_sticky", 32'(eret_err), 32'h1);

        // Global disable with a held level, then reset mid-handler.
        do_reset();
        gie_we = 1'b1; gie_wdata = 1'b0;
        cyc();
        gie_we = 1'b0;
        #1;
        chk("t6_gie0", 32'(gie), 32'h0);
        irq_in = 8'h04;
        repeat (10) cyc();
        chk("t6_one_pend", 32'(pending), 32'h04);
        chk("t6_no_take", 32'(take), 32'h0);
        gie_we = 1'b1; gie_wdata = 1'b1;
        #1;
        chk("t6_old_gie", 32'(take), 32'h0);
        cyc();
        gie_we = 1'b0;
        #1;
        chk("t6_take", 32'(take), 32'h1);
        chk("t6_vector", vector, 32'h420);
        cyc();
        chk("t6_depth", 32'(depth), 32'h1);
        chk("t6_single", 32'(take), 32'h0);
        chk("t6_pend_clr", 32'(pending), 32'h00);
        rst = 1'b1;
        #1;
        chk("t6_rst_depth", 32'(depth), 32'h0);
        chk("t6_rst_insvc", 32'(in_service), 32'h00);
        chk("t6_rst_epc", epc, 32'h0);
        chk("t6_rst_take", 32'(take), 32'h0);
        chk("t6_rst_gie", 32'(gie), 32'h1);
        irq_in = '0;
        cyc();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
